ram_writer: RTL and testbench

RAM_WRITER -- requirements
Module: ram_writer

---
 rtl/ram_pkg.sv | 9 +
 rtl/ram_core.sv | 32 +++
 rtl/ram_writer.sv | 113 +++++++++++
 tb/tb_ram_writer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared widths and FSM state encoding for the RAM writer.
//   ADDR_WIDTH  default address width (depth = 2**ADDR_WIDTH)
//   DATA_WIDTH  default data word width
//   wr_state_t  writer FSM states
package ram_pkg;
   localparam int ADDR_WIDTH = 2;
   localparam int DATA_WIDTH = 4;
   typedef enum logic [1:0] {IDLE, BURST, CLEAR} wr_state_t;
endpackage

// File: rtl/ram_core.sv
// ram_core: register-array storage with one write port and one combinational read port.
//   clk, rst_n  clock, async active-low reset (zeroes every entry)
//   we          write enable; waddr/wdata written at the rising edge
//   raddr       read address; rdata shows the pre-edge contents (read-before-write)
module ram_core #(
   parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/ram_writer.sv
// ram_writer: write controller with single writes, wrapping bursts and a full-memory clear.
//   clk, rst_n              clock, async active-low reset
//   wr_valid/wr_ready       write handshake; wr_addr used outside bursts, wr_data always
//   burst_start/base/len    start a burst at base for len words (len 0 means full depth)
//   clear                   zero the whole memory, one entry per cycle
//   rd_addr/rd_data         combinational read port
//   busy                    high while bursting or clearing
//   written/all_written     per-entry written flags and their AND
module ram_writer #(
   parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    burst_start,
   input  logic [ADDR_WIDTH-1:0]   burst_base,
   input  logic [ADDR_WIDTH:0]     burst_len,
   input  logic                    clear,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    busy,
   output logic [2**ADDR_WIDTH-1:0] written,
   output logic                    all_written
);
   import ram_pkg::*;
   localparam int DEPTH = 2**ADDR_WIDTH;
   wr_state_t state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, cnt_q, cnt_d, waddr;
   logic [ADDR_WIDTH:0]   rem_q, rem_d;
   logic [DEPTH-1:0]      written_q, written_d;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  we;
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      written_d = written_q;
      wr_ready  = 1'b0;
      we        = 1'b0;
      waddr     = wr_addr;
      wdata     = wr_data;
      case (state_q)
         IDLE: begin
            // clear and burst_start both steal the cycle from a pending write
            wr_ready = !clear && !burst_start;
            we       = wr_valid && wr_ready;
            if (clear) begin
               state_d   = CLEAR;
               written_d = '0;
            end else if (burst_start) begin
               state_d = BURST;
               ptr_d   = burst_base;
               rem_d   = (burst_len == '0) ? (ADDR_WIDTH+1)'(DEPTH) : burst_len;
            end
         end
         BURST: begin
            wr_ready = !clear;
            we       = wr_valid && wr_ready;
            waddr    = ptr_q;
            if (clear) begin
               state_d   = CLEAR;
               written_d = '0;
            end else if (we) begin
               ptr_d = ptr_q + ADDR_WIDTH'(1);
               rem_d = rem_q - (ADDR_WIDTH+1)'(1);
               if (rem_q == (ADDR_WIDTH+1)'(1)) state_d = IDLE;
            end
         end
         CLEAR: begin
            we    = 1'b1;
            waddr = cnt_q;
            wdata = '0;
            // counter wraps back to 0 on the last entry, ready for the next clear
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (&cnt_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (we && state_q != CLEAR) written_d[waddr] = 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         written_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         written_q <= written_d;
      end
   end
   ram_core #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (rd_addr),
      .rdata (rd_data)
   );
   assign busy        = (state_q != IDLE);
   assign written     = written_q;
   assign all_written = &written_q;
endmodule

// File: tb/tb_ram_writer.sv
// tb_ram_writer: directed self-checking bench for ram_writer (depth 4, 4-bit data).
module tb_ram_writer;
   logic       clk = 1'b0;
   logic       rst_n, wr_valid, wr_ready, burst_start, clear, busy, all_written;
   logic [1:0] wr_addr, burst_base, rd_addr;
   logic [2:0] burst_len;
   logic [3:0] wr_data, rd_data, written;
   int checks = 0;
   int failures = 0;

   ram_writer dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .burst_start(burst_start),
      .burst_base(burst_base), .burst_len(burst_len), .clear(clear),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .written(written),
      .all_written(all_written)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [3:0] exp);
      rd_addr = a;
      #1;
      chk(tag, rd_data, exp);
   endtask

   initial begin
      rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; burst_start = 1'b0;
      burst_base = '0; burst_len = '0; clear = 1'b0; rd_addr = '0;
      #2;
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_all_written", all_written, 0);
      chk("rst_written", written, 4'b0000);
      chk("rst_rd_data", rd_data, 0);
      #10 rst_n = 1'b1;
      tick();
      // single write addr 2 = 0110
      wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 4'b0110;
      #1 chk("idle_wr_ready", wr_ready, 1);
      tick();
      wr_valid = 1'b0;
      rd("single_rd", 2'd2, 4'b0110);
      chk("single_written", written, 4'b0100);
      chk("single_all_written", all_written, 0);
      // burst base 3 len 3, same-cycle write must be dropped
      burst_start = 1'b1; burst_base = 2'd3; burst_len = 3'd3;
      wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 4'hF;
      #1 chk("bstart_wr_ready", wr_ready, 0);
      tick();
      burst_start = 1'b0; wr_data = 4'b0100;
      #1 chk("burst_busy0", busy, 1);
      chk("burst_wr_ready", wr_ready, 1);
      rd("bstart_dropped", 2'd2, 4'b0110);
      tick();
      wr_valid = 1'b0;
      #1 chk("burst_busy_gap", busy, 1);
      rd("burst_beat1", 2'd3, 4'b0100);
      tick();
      wr_valid = 1'b1; wr_data = 4'b1100;
      #1 chk("burst_busy2", busy, 1);
      tick();
      wr_data = 4'b0111;
      #1 chk("burst_busy3", busy, 1);
      tick();
      wr_valid = 1'b0;
      #1 chk("burst_done_busy", busy, 0);
      rd("burst_mem3", 2'd3, 4'b0100);
      rd("burst_mem0", 2'd0, 4'b1100);
      rd("burst_mem1", 2'd1, 4'b0111);
      chk("burst_written", written, 4'b1111);
      chk("burst_all_written", all_written, 1);
      // read-before-write on addr 1: set 1100, then write 0111 while reading
      wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 4'b1100;
      tick();
      wr_data = 4'b0111;
      rd("rbw_old", 2'd1, 4'b1100);
      tick();
      wr_valid = 1'b0;
      rd("rbw_new", 2'd1, 4'b0111);
      // clear with concurrent write; stray write and burst_start during clear ignored
      clear = 1'b1; wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 4'h9;
      #1 chk("clr_wr_ready", wr_ready, 0);
      tick();
      clear = 1'b0; wr_valid = 1'b0;
      #1 chk("clr_busy1", busy, 1);
      chk("clr_written0", written, 4'b0000);
      chk("clr_wr_ready_busy", wr_ready, 0);
      tick();
      wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 4'h5; clear = 1'b1;
      #1 chk("clr_busy2", busy, 1);
      tick();
      wr_valid = 1'b0; clear = 1'b0;
      #1 chk("clr_busy3", busy, 1);
      tick();
      burst_start = 1'b1; burst_base = 2'd2; burst_len = 3'd1;
      #1 chk("clr_busy4", busy, 1);
      tick();
      burst_start = 1'b0;
      #1 chk("clr_done_busy", busy, 0);
      chk("clr_written", written, 4'b0000);
      chk("clr_all_written", all_written, 0);
      for (int i = 0; i < 4; i++) rd($sformatf("clr_mem%0d", i), 2'(i), 4'h0);
      // burst_len 0 means full depth
      burst_start = 1'b1; burst_base = 2'd1; burst_len = 3'd0;
      tick();
      burst_start = 1'b0; wr_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         wr_data = 4'(i);
         #1 chk($sformatf("len0_busy%0d", i), busy, 1);
         tick();
      end
      wr_valid = 1'b0;
      #1 chk("len0_busy_end", busy, 0);
      chk("len0_all_written", all_written, 1);
      rd("len0_mem1", 2'd1, 4'd1);
      rd("len0_mem2", 2'd2, 4'd2);
      rd("len0_mem3", 2'd3, 4'd3);
      rd("len0_mem0", 2'd0, 4'd4);
      // reset during second burst beat
      burst_start = 1'b1; burst_base = 2'd0; burst_len = 3'd2;
      tick();
      burst_start = 1'b0; wr_valid = 1'b1; wr_data = 4'hA;
      tick();
      wr_data = 4'hB;
      #1 rst_n = 1'b0;
      #1 chk("rstb_busy", busy, 0);
      chk("rstb_wr_ready", wr_ready, 1);
      chk("rstb_written", written, 4'b0000);
      rd("rstb_mem0", 2'd0, 4'h0);
      wr_valid = 1'b0;
      #1 rst_n = 1'b1;
      tick();
      chk("rstb_busy_after", busy, 0);
      chk("rstb_written_after", written, 4'b0000);
      for (int i = 0; i < 4; i++) rd($sformatf("rstb_mem%0d", i), 2'(i), 4'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
